// File: rtl/datapath_seq_pkg.sv
// Shared definitions for the datapath instruction sequencer: ALU op codes,
// instruction field layout and FSM state encoding.
package datapath_seq_pkg;

  localparam int INSTR_W = 9;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3
  } op_e;

  // Field order matches the encoding: [8:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2.
  // op stays a raw 3-bit field so illegal encodings can be carried and flagged.
  typedef struct packed {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'(OP_XOR);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// DEPTH x W synchronous FIFO with occupancy count; DEPTH must be a power of two
// so the pointers wrap naturally.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic          full, push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q];
  assign level_o = level_q;

  // Storage needs no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/datapath_seq.sv
// Instruction sequencer: buffers instructions and drives the datapath with a
// SETUP (wr=0) then WRITE (wr=1) cycle per instruction, all outputs registered.
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_W-1:0]     in_instr,
  output logic [1:0]             addr1,
  output logic [1:0]             addr2,
  output logic [1:0]             addr3,
  output logic [2:0]             alucontrol,
  output logic                   wr,
  output logic                   busy,
  output logic                   retire,
  output logic                   err,
  output logic [CNT_W-1:0]       retired_cnt,
  output logic [$clog2(DEPTH):0] level
);
  localparam int LW = $clog2(DEPTH) + 1;

  state_e             state_q;
  instr_t             instr_q, head;
  logic               wr_q, retire_q, err_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INSTR_W-1:0] fifo_dout;
  logic [LW-1:0]      fifo_level;
  logic               fifo_empty, push, pop;

  assign in_ready = (fifo_level != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  // Pop only in states that hand off to SETUP, so WRITE chains straight into the next SETUP.
  assign pop      = !fifo_empty && (state_q == ST_IDLE || state_q == ST_WRITE);
  assign head     = instr_t'(fifo_dout);
  assign cnt_d    = cnt_q + CNT_W'(1);

  instr_fifo #(.DEPTH(DEPTH), .W(INSTR_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (in_instr),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .level_o (fifo_level),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      wr_q     <= 1'b0;
      retire_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wr_q     <= 1'b0;
          retire_q <= 1'b0;
          if (!fifo_empty) begin
            instr_q <= head;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          wr_q     <= op_legal(instr_q.op);
          retire_q <= op_legal(instr_q.op);
          state_q  <= ST_WRITE;
        end
        ST_WRITE: begin
          wr_q     <= 1'b0;
          retire_q <= 1'b0;
          if (op_legal(instr_q.op)) cnt_q <= cnt_d;
          else                      err_q <= 1'b1;
          if (!fifo_empty) begin
            instr_q <= head;
            state_q <= ST_SETUP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          wr_q     <= 1'b0;
          retire_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign addr1       = instr_q.rs1;
  assign addr2       = instr_q.rs2;
  assign addr3       = instr_q.rd;
  assign alucontrol  = instr_q.op;
  assign wr          = wr_q;
  assign retire      = retire_q;
  assign err         = err_q;
  assign retired_cnt = cnt_q;
  assign level       = fifo_level;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq with a behavioural 4x32 register-file model
// standing in for the datapath.
module tb_datapath_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_instr = '0;
  logic [1:0]  addr1, addr2, addr3;
  logic [2:0]  alucontrol;
  logic        wr, busy, retire, err;
  logic [15:0] retired_cnt;
  logic [2:0]  level;

  int total = 0;
  int bad   = 0;

  datapath_seq #(.DEPTH(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .addr1       (addr1),
    .addr2       (addr2),
    .addr3       (addr3),
    .alucontrol  (alucontrol),
    .wr          (wr),
    .busy        (busy),
    .retire      (retire),
    .err         (err),
    .retired_cnt (retired_cnt),
    .level       (level)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: writes rd on the edge that ends a wr=1 cycle.
  logic [3:0][31:0] dp, dp_init;
  logic             dp_load = 1'b0;

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a ^ b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (dp_load)  dp <= dp_init;
    else if (wr)  dp[addr3] <= alu(alucontrol, dp[addr1], dp[addr2]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_regs(input logic [31:0] r0, r1, r2, r3);
    dp_init = {r3, r2, r1, r0};
    dp_load = 1'b1;
    tick();
    dp_load = 1'b0;
  endtask

  logic [8:0] bp [7];
  logic [7:0] pat;
  logic       acc, saw_full;
  int         k, n, ready_bad, activity;

  initial begin
    bp[0] = 9'h006; bp[1] = 9'h09B; bp[2] = 9'h0F8; bp[3] = 9'h04F;
    bp[4] = 9'h0C5; bp[5] = 9'h012; bp[6] = 9'h0A7;

    // Reset with in_valid high must not push anything
    in_valid = 1'b1;
    in_instr = 9'h006;
    tick(); tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_level", level, 0);
    chk("rst_addrs", {addr1, addr2, addr3, alucontrol}, 0);
    chk("rst_flags", {wr, busy, retire, err}, 0);
    chk("rst_cnt", retired_cnt, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("rst_release_level", level, 0);

    // Single ADD: R0 = R1 + R2 = 5 + 3
    load_regs(0, 5, 3, 7);
    in_valid = 1'b1; in_instr = 9'h006;
    tick();
    in_valid = 1'b0;
    chk("single_busy_queued", busy, 1);
    tick();
    chk("single_setup", {addr1, addr2, addr3, alucontrol, wr}, {2'd1, 2'd2, 2'd0, 3'd0, 1'b0});
    tick();
    chk("single_write", {wr, retire}, 2'b11);
    tick();
    chk("single_after", {wr, retire, busy}, 3'b000);
    chk("single_cnt", retired_cnt, 1);
    chk("single_r0", dp[0], 8);

    // Back-to-back four instructions
    do_reset();
    load_regs(0, 5, 3, 7);
    pat = '0;
    for (int i = 0; i < 9; i++) begin
      if (i < 4) begin in_valid = 1'b1; in_instr = bp[i]; end
      else in_valid = 1'b0;
      tick();
      if (i >= 1) pat[i-1] = wr;
    end
    tick();
    chk("b2b_wr_pattern", pat, 8'hAA);
    chk("b2b_cnt", retired_cnt, 4);
    chk("b2b_busy", busy, 0);
    chk("b2b_r0", dp[0], 0);
    chk("b2b_r1", dp[1], 3);
    chk("b2b_r2", dp[2], 3);
    chk("b2b_r3", dp[3], 11);

    // Back-pressure: 7 instructions with in_valid held while any remain
    do_reset();
    k = 0; n = 0; ready_bad = 0; saw_full = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (k < 7) begin in_valid = 1'b1; in_instr = bp[k]; end
      else in_valid = 1'b0;
      acc = in_valid && in_ready;
      if (level == 3'd4) begin
        saw_full = 1'b1;
        if (in_ready) ready_bad++;
      end
      tick();
      if (acc) k++;
      if (wr) begin
        if (n < 7) chk("bp_order", {alucontrol, addr3, addr1, addr2}, bp[n]);
        n++;
      end
    end
    chk("bp_accepted", k, 7);
    chk("bp_executed", n, 7);
    chk("bp_cnt", retired_cnt, 7);
    chk("bp_ready_when_full", ready_bad, 0);
    chk("bp_reached_full", saw_full, 1);

    // Illegal op followed by a legal ADD
    do_reset();
    in_valid = 1'b1; in_instr = 9'h160;
    tick();
    in_instr = 9'h006;
    tick();
    in_valid = 1'b0;
    chk("ill_setup", {addr3, alucontrol, wr}, {2'd2, 3'd5, 1'b0});
    tick();
    chk("ill_write", {wr, retire, err}, 3'b000);
    tick();
    chk("ill_err_set", err, 1);
    chk("ill_cnt0", retired_cnt, 0);
    chk("ill_next_setup", {addr1, wr}, {2'd1, 1'b0});
    tick();
    chk("ill_next_write", {wr, retire}, 2'b11);
    tick();
    chk("ill_cnt1", retired_cnt, 1);
    chk("ill_err_sticky", {err, busy}, 2'b10);

    // Reset in the middle of a WRITE with three queued
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = bp[i];
      tick();
    end
    in_valid = 1'b0;
    chk("mid_pre_wr", wr, 1);
    chk("mid_pre_level", level, 3);
    #2 rst = 1'b1;
    #1;
    chk("mid_async_wr", wr, 0);
    chk("mid_async_level", level, 0);
    chk("mid_async_flags", {in_ready, busy, retire}, 3'b100);
    @(posedge clk);
    #1 rst = 1'b0;
    activity = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wr || busy) activity++;
    end
    chk("mid_no_activity", activity, 0);
    chk("mid_cnt", retired_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datapath_seq.md
# datapath_seq

Instruction sequencer for the 4-register, 32-bit `datapath` block. Accepts encoded register-to-register instructions over a valid/ready interface and buffers them in a small FIFO. Drives the datapath's `addr1`/`addr2`/`addr3`/`alucontrol`/`wr` inputs as a two-cycle setup/write sequence per instruction, with retirement status. The sequencer sits between the instruction source and the datapath, replacing hand-driven stimulus.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: `in_instr` is valid.
- `in_ready`  out  1: FIFO can accept; equals `level != DEPTH`.
- `in_instr`  in  9: instruction fields:
  - [8:6] op
  - [5:4] rd
  - [3:2] rs1
  - [1:0] rs2
- `addr1`  out  2: datapath read port 1 (rs1).
- `addr2`  out  2: datapath read port 2 (rs2).
- `addr3`  out  2: datapath write address (rd).
- `alucontrol`  out  3: datapath ALU op.
- `wr`  out  1: datapath register write enable.
- `busy`  out  1: FSM not in IDLE or FIFO non-empty.
- `retire`  out  1: one-cycle pulse per successfully written instruction.
- `err`  out  1: sticky flag, set on illegal op; cleared only by reset.
- `retired_cnt`  out  CNT_W: count of retired instructions; wraps modulo 2^CNT_W.
- `level`  out  clog2(DEPTH)+1: FIFO occupancy.

## Operation
- Legal ops:
  - 000 ADD
  - 001 SUB (rs1 − rs2)
  - 010 AND
  - 011 XOR
- Ops 100–111 are illegal.
- FIFO push occurs on any edge with `in_valid && in_ready`. A push when full is impossible, because `in_ready` is low. Simultaneous push and pop is allowed whenever not full.
- The FSM has three states: IDLE, SETUP, WRITE.
  - IDLE: if FIFO non-empty, pop into the instruction register and go to SETUP; otherwise stay in IDLE.
  - SETUP: `addr1`=rs1, `addr2`=rs2, `addr3`=rd, `alucontrol`=op, `wr`=0. Always go to WRITE next.
  - WRITE: addresses and op are held, and `wr`=1 if the op is legal. If FIFO non-empty, pop and go directly to SETUP; otherwise go to IDLE.
- Illegal op: the WRITE cycle runs with `wr`=0, `err` is set at the end of that cycle, and there is no `retire` and no count increment. The instruction is still consumed and sequencing continues.
- `retire`=1 and `retired_cnt` increments during/at the end of every legal WRITE cycle.
- Instructions execute strictly in FIFO order. There are no hazards, since each instruction completes its datapath write before the next SETUP.
- In IDLE, outputs hold their last values except `wr`=0 and `retire`=0.

## Timing
- All outputs are registered from state and the instruction register. There is no combinational path from `in_*` to datapath outputs; `in_ready` depends only on `level`.
- Reset values:
  - state IDLE; FIFO empty, `level`=0, `in_ready`=1
  - `addr1`/`addr2`/`addr3`=0, `alucontrol`=0
  - `wr`=0, `busy`=0, `retire`=0, `err`=0, `retired_cnt`=0
- Latency from empty/IDLE:
  - Instruction accepted at edge E0.
  - Popped at E1; SETUP cycle is E1–E2.
  - WRITE cycle is E2–E3; the datapath register is written at E3.
- Throughput is one instruction per 2 cycles when the FIFO is non-empty, with no bubbles between WRITE and the next SETUP.
- Reset mid-operation takes effect immediately. `wr` drops asynchronously and any partially executed instruction is discarded. All queued instructions are lost.

## Structure
- Shared definitions file `datapath_defs.vh`, also usable by `datapath`, contains:
  - ALU op codes (ADD/SUB/AND/XOR)
  - instruction field bit positions
  - FSM state encodings
- Sub-module `instr_fifo`: parameterised DEPTH × 9 synchronous FIFO with push/pop/level, asynchronous reset.
- `datapath_seq` contains the FSM, instruction register, `err`, and `retired_cnt`.

## Test plan
- Reset check: assert `rst` with `in_valid`=1. Required: all outputs at reset values, `in_ready`=1, no push.
- Single instruction 9'h006 (ADD, rd=0, rs1=1, rs2=2), datapath R1=5, R2=3:
  - SETUP cycle: `addr1`=1, `addr2`=2, `addr3`=0, `alucontrol`=0, `wr`=0.
  - Next cycle: `wr`=1, `retire`=1.
  - Datapath R0=8 afterwards; `retired_cnt`=1; back to IDLE, `busy`=0.
- Back-to-back 9'h006, 9'h09B, 9'h0F8, 9'h04F:
  - `wr` pattern 0,1,0,1,0,1,0,1 with no gaps.
  - Datapath results are golden-model checked.
  - `retired_cnt`=4.
- Back-pressure: DEPTH=4, stream 7 instructions with `in_valid` held high. Required: `in_ready` low whenever `level`=4, all 7 executed in order, `retired_cnt`=7.
- Illegal op 9'h160 followed by 9'h006:
  - Illegal instruction: WRITE cycle `wr`=0, no `retire`, `err`=1 thereafter.
  - Second instruction executes normally; `retired_cnt`=1.
- Reset asserted mid-WRITE with 3 instructions queued: `wr`=0 immediately, `level`=0, no further SETUP/WRITE after release.
